// File: rtl/snake_pkg.sv
// Shared definitions for the snake game event path.
// Provides the direction index constants, the 4-bit direction vector type
// and a helper that resolves simultaneous direction requests to a single
// winning bit.
package snake_pkg;

  localparam int unsigned DIR_UP    = 3;
  localparam int unsigned DIR_DOWN  = 2;
  localparam int unsigned DIR_LEFT  = 1;
  localparam int unsigned DIR_RIGHT = 0;

  typedef logic [3:0] dir_vec_t;

  // Highest index wins: up > down > left > right. Result is one-hot or zero.
  function automatic dir_vec_t dir_pick(input dir_vec_t req);
    dir_vec_t win;
    win = '0;
    if (req[DIR_UP]) begin
      win[DIR_UP] = 1'b1;
    end else if (req[DIR_DOWN]) begin
      win[DIR_DOWN] = 1'b1;
    end else if (req[DIR_LEFT]) begin
      win[DIR_LEFT] = 1'b1;
    end else if (req[DIR_RIGHT]) begin
      win[DIR_RIGHT] = 1'b1;
    end
    return win;
  endfunction

endpackage

// File: rtl/stretch_chan.sv
// One pulse-stretching channel.
// Ports:
//   clk  - system clock
//   nRst - asynchronous active-low reset
//   clr  - synchronous clear (highest priority)
//   ev   - single-cycle event request
//   kill - forces the channel idle (below clr, above ev)
//   lvl  - stretched level, high while the hold counter is non-zero
module stretch_chan #(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter bit          RETRIGGER   = 1'b1
) (
  input  logic clk,
  input  logic nRst,
  input  logic clr,
  input  logic ev,
  input  logic kill,
  output logic lvl
);

  localparam int unsigned    CW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0]  HOLD_VAL = CW'(HOLD_CYCLES);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          accept;

  always_comb begin
    accept = ev && ((cnt_q == '0) || RETRIGGER);
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (kill) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = HOLD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign lvl = (cnt_q != '0);

endmodule

// File: rtl/event_stretcher.sv
// Turns single-cycle game event pulses into levels held for HOLD_CYCLES.
// Ports:
//   clk, nRst             - clock, asynchronous active-low reset
//   clr                   - synchronous clear of all channels
//   goodColl_p, badColl_p - collision event pulses
//   button_p              - button event pulse
//   direction_p[3:0]      - direction pulses ([3]=up [2]=down [1]=left [0]=right)
//   *_lvl                 - stretched levels; direction_lvl is at most one-hot
//   busy                  - OR of all level outputs
module event_stretcher
  import snake_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter bit          RETRIGGER   = 1'b1
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       clr,
  input  logic       goodColl_p,
  input  logic       badColl_p,
  input  logic       button_p,
  input  logic [3:0] direction_p,
  output logic       goodColl_lvl,
  output logic       badColl_lvl,
  output logic       button_lvl,
  output logic [3:0] direction_lvl,
  output logic       busy
);

  dir_vec_t dir_win;
  dir_vec_t dir_kill;
  dir_vec_t dir_lvl;
  logic     dir_accept;

  // Only the winning direction is offered to its channel. The others are
  // killed only when that channel actually takes the event, so a rejected
  // retrigger leaves the group untouched.
  always_comb begin
    dir_win    = dir_pick(direction_p);
    dir_accept = |(dir_win & (~dir_lvl | {4{RETRIGGER}}));
    dir_kill   = dir_accept ? ~dir_win : '0;
  end

  for (genvar i = 0; i < 4; i++) begin : g_dir
    stretch_chan #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .RETRIGGER   (RETRIGGER)
    ) u_chan (
      .clk  (clk),
      .nRst (nRst),
      .clr  (clr),
      .ev   (dir_win[i]),
      .kill (dir_kill[i]),
      .lvl  (dir_lvl[i])
    );
  end

  stretch_chan #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .RETRIGGER   (RETRIGGER)
  ) u_good (
    .clk  (clk),
    .nRst (nRst),
    .clr  (clr),
    .ev   (goodColl_p),
    .kill (1'b0),
    .lvl  (goodColl_lvl)
  );

  stretch_chan #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .RETRIGGER   (RETRIGGER)
  ) u_bad (
    .clk  (clk),
    .nRst (nRst),
    .clr  (clr),
    .ev   (badColl_p),
    .kill (1'b0),
    .lvl  (badColl_lvl)
  );

  stretch_chan #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .RETRIGGER   (RETRIGGER)
  ) u_button (
    .clk  (clk),
    .nRst (nRst),
    .clr  (clr),
    .ev   (button_p),
    .kill (1'b0),
    .lvl  (button_lvl)
  );

  assign direction_lvl = dir_lvl;
  assign busy          = goodColl_lvl | badColl_lvl | button_lvl | (|dir_lvl);

endmodule
